// File: rtl/vc_egress_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vc_egress_sink : two-port egress sink FIFOs, pause generation, link FSM.    |
// | Define VC_SINK_WATERMARK_EN to add per-port high-water-mark outputs.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vc_egress_sink #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [AW:0]       umbral_p0,
  input  logic [AW:0]       umbral_p1,
  input  logic              push_p0,
  input  logic [DATA_W-1:0] data_in_p0,
  input  logic              push_p1,
  input  logic [DATA_W-1:0] data_in_p1,
  input  logic              pop_p0,
  input  logic              pop_p1,
  output logic [DATA_W-1:0] data_out_p0,
  output logic              valid_out_p0,
  output logic [DATA_W-1:0] data_out_p1,
  output logic              valid_out_p1,
  output logic              pause_p0,
  output logic              pause_p1,
  output logic [AW:0]       count_p0,
  output logic [AW:0]       count_p1,
`ifdef VC_SINK_WATERMARK_EN
  output logic [AW:0]       hwm_p0,
  output logic [AW:0]       hwm_p1,
`endif
  output logic              active_out,
  output logic              idle_out,
  output logic              error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t state_q, state_d;
  logic   active_q, idle_q, error_q;
  logic   accept;
  logic   pause_en;
  logic   err_ev;
  logic   drained;

  // Writes and reads only move while the link is up and no config window is open.
  assign accept   = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) && !init;
  assign pause_en = (state_q != ST_RESET) && (state_q != ST_INIT);

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              push_i, pop_i;
    logic [DATA_W-1:0] din_i;
    logic [AW:0]       umbral_i;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d, thr_q, thr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovf, unf, wr_en, rd_en, pause;

    assign push_i   = (p == 0) ? push_p0    : push_p1;
    assign pop_i    = (p == 0) ? pop_p0     : pop_p1;
    assign din_i    = (p == 0) ? data_in_p0 : data_in_p1;
    assign umbral_i = (p == 0) ? umbral_p0  : umbral_p1;

    always_comb begin
      ovf      = accept && push_i && !pop_i && (count_q == FULL);
      // An empty pop is a fault even with a same-cycle push: no bypass, push dropped too.
      unf      = accept && pop_i && (count_q == '0);
      wr_en    = accept && push_i && !ovf && !unf;
      rd_en    = accept && pop_i && !unf;
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(rd_en);
      count_d  = count_q;
      if (wr_en && !rd_en) begin
        count_d = count_q + ONE;
      end else if (rd_en && !wr_en) begin
        count_d = count_q - ONE;
      end
      if (init) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      thr_d   = init ? umbral_i : thr_q;
      dout_d  = rd_en ? mem_q[rd_ptr_q] : dout_q;
      valid_d = rd_en;
    end

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        thr_q    <= '0;
        dout_q   <= '0;
        valid_q  <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        thr_q    <= thr_d;
        dout_q   <= dout_d;
        valid_q  <= valid_d;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end

    assign pause = pause_en && (thr_q != '0) && (count_q >= thr_q);

`ifdef VC_SINK_WATERMARK_EN
    logic [AW:0] hwm_q, hwm_d;

    always_comb begin
      hwm_d = hwm_q;
      if (init) begin
        hwm_d = '0;
      end else if (count_d > hwm_q) begin
        hwm_d = count_d;
      end
    end

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        hwm_q <= '0;
      end else begin
        hwm_q <= hwm_d;
      end
    end
`endif
  end

  assign err_ev  = g_port[0].ovf || g_port[0].unf || g_port[1].ovf || g_port[1].unf;
  assign drained = (g_port[0].count_q == '0) && (g_port[1].count_q == '0) &&
                   !push_p0 && !push_p1;

  // Priority: init beats fault detection, which beats the normal transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   if (push_p0 || push_p1) state_d = ST_ACTIVE;
      ST_ACTIVE: if (drained) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    if (err_ev) begin
      state_d = ST_ERROR;
    end
    if (init) begin
      state_d = ST_INIT;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= (state_d == ST_ACTIVE);
      idle_q   <= (state_d == ST_IDLE);
      error_q  <= (state_d == ST_ERROR);
    end
  end

  assign data_out_p0  = g_port[0].dout_q;
  assign valid_out_p0 = g_port[0].valid_q;
  assign data_out_p1  = g_port[1].dout_q;
  assign valid_out_p1 = g_port[1].valid_q;
  assign pause_p0     = g_port[0].pause;
  assign pause_p1     = g_port[1].pause;
  assign count_p0     = g_port[0].count_q;
  assign count_p1     = g_port[1].count_q;
`ifdef VC_SINK_WATERMARK_EN
  assign hwm_p0       = g_port[0].hwm_q;
  assign hwm_p1       = g_port[1].hwm_q;
`endif
  assign active_out   = active_q;
  assign idle_out     = idle_q;
  assign error_out    = error_q;

endmodule
`default_nettype wire
